// File: rtl/iob_uart_rx_fifo.sv
// rtl/iob_uart_rx_fifo.sv - RS-232 receiver feeding a first-word-fall-through byte FIFO
//
// Deserialises 8N1 frames (8E1 when IOB_UART_RX_PARITY_EN is defined) at a
// programmable baud divisor. Received bytes are queued in a FWFT FIFO and
// presented on a valid/ready stream. rs232_rts_o provides hardware flow control
// towards the peer transmitter.
//
// Optional feature macro: IOB_UART_RX_PARITY_EN (adds PARITY state and parity_err_o)
//
// Ports:
//   clk_i, arst_n_i   clock, asynchronous active-low reset
//   en_i              receiver enable (low forces the FSM to idle, disarmed)
//   div_i             clock cycles per bit (>= 8)
//   rs232_rxd_i       asynchronous serial input, idles high
//   rs232_rts_o       1 = ready to receive (registered)
//   data_o, valid_o   FIFO head byte and non-empty flag
//   ready_i           consumer pop strobe (qualified by valid_o)
//   level_o           FIFO occupancy, 0..2**FIFO_ADDR_W
//   frame_err_o       sticky, stop bit sampled low
//   overflow_o        sticky, byte dropped because FIFO was full with no pop
//   clr_err_i         synchronous clear of the sticky flags
//   parity_err_o      sticky, even-parity mismatch (parity build only)

module iob_uart_rx_fifo #(
  parameter int DIV_W       = 16,
  parameter int FIFO_ADDR_W = 4,
  parameter int RTS_MARGIN  = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   en_i,
  input  logic [DIV_W-1:0]       div_i,
  input  logic                   rs232_rxd_i,
  output logic                   rs232_rts_o,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [FIFO_ADDR_W:0]   level_o,
  output logic                   frame_err_o,
  output logic                   overflow_o,
`ifdef IOB_UART_RX_PARITY_EN
  output logic                   parity_err_o,
`endif
  input  logic                   clr_err_i
);

  localparam int DEPTH = 2 ** FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] DEPTH_L  = (FIFO_ADDR_W+1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0] MARGIN_L = (FIFO_ADDR_W+1)'(RTS_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IOB_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser; both flops preset to the idle line level
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rs232_rxd_i;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t           state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shift, shift_d;
  logic             armed, armed_d;
  logic             push;
  logic             frame_set;
  logic             tick;
  logic [DIV_W-1:0] full_load;
  logic [DIV_W-1:0] half_load;
`ifdef IOB_UART_RX_PARITY_EN
  logic             par_bad, par_bad_d;
  logic             par_set;
`endif

  // div_i is consumed only at load time, so a mid-frame change affects
  // only the bit periods loaded after it.
  assign full_load = div_i - DIV_W'(1);
  assign half_load = (div_i >> 1) - DIV_W'(1);
  assign tick      = (cnt == '0);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      armed   <= 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      shift   <= shift_d;
      armed   <= armed_d;
`ifdef IOB_UART_RX_PARITY_EN
      par_bad <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    idx_d     = idx;
    shift_d   = shift;
    armed_d   = armed;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
    par_bad_d = par_bad;
    par_set   = 1'b0;
`endif
    if (!en_i) begin
      state_d = S_IDLE;
      armed_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A line held low (break, or after a framing error) must go high
          // before the next falling edge may start a frame.
          if (!armed) begin
            if (rxs) armed_d = 1'b1;
          end else if (!rxs) begin
            cnt_d   = half_load;
            state_d = S_START;
          end
        end
        S_START: begin
          if (!tick) begin
            cnt_d = cnt - DIV_W'(1);
          end else if (rxs) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = full_load;
            idx_d   = 3'd0;
            state_d = S_DATA;
`ifdef IOB_UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (!tick) begin
            cnt_d = cnt - DIV_W'(1);
          end else begin
            shift_d = {rxs, shift[7:1]};
            cnt_d   = full_load;
            idx_d   = idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef IOB_UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef IOB_UART_RX_PARITY_EN
        S_PARITY: begin
          if (!tick) begin
            cnt_d = cnt - DIV_W'(1);
          end else begin
            // Even parity: data bits plus parity bit must XOR to 0.
            par_bad_d = (^shift) ^ rxs;
            par_set   = par_bad_d;
            cnt_d     = full_load;
            state_d   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!tick) begin
            cnt_d = cnt - DIV_W'(1);
          end else begin
            if (rxs) begin
`ifdef IOB_UART_RX_PARITY_EN
              push = !par_bad;
`else
              push = 1'b1;
`endif
            end else begin
              frame_set = 1'b1;
              armed_d   = 1'b0;
            end
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]             mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic [FIFO_ADDR_W:0]   level;
  logic [FIFO_ADDR_W:0]   level_d;
  logic                   full;
  logic                   pop;
  logic                   wr_en;
  logic                   ovf_set;

  assign full    = (level == DEPTH_L);
  assign valid_o = (level != '0);
  assign pop     = valid_o && ready_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    level_d = level;
    if (wr_en && !pop)      level_d = level + (FIFO_ADDR_W+1)'(1);
    else if (!wr_en && pop) level_d = level - (FIFO_ADDR_W+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rs232_rts_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
      level       <= level_d;
      rs232_rts_o <= (DEPTH_L - level_d) > MARGIN_L;
    end
  end

  // Head byte is masked while empty so the output reads 0 out of reset.
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;
  assign level_o = level;

  // ---------------------------------------------------------------------------
  // Sticky error flags (set wins over clear)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      if (frame_set)      frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;
      if (ovf_set)        overflow_o  <= 1'b1;
      else if (clr_err_i) overflow_o  <= 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
      if (par_set)        parity_err_o <= 1'b1;
      else if (clr_err_i) parity_err_o <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_iob_uart_rx_fifo.sv
// tb/tb_iob_uart_rx_fifo.sv - directed self-checking bench for iob_uart_rx_fifo

module tb_iob_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        en;
  logic [15:0] div;
  logic        rxd;
  logic        rts;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [4:0]  level;
  logic        frame_err;
  logic        overflow;
  logic        clr_err;
`ifdef IOB_UART_RX_PARITY_EN
  logic        parity_err;
  localparam int FX = 16;
`else
  localparam int FX = 0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iob_uart_rx_fifo #(.DIV_W(16), .FIFO_ADDR_W(4), .RTS_MARGIN(4)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .en_i        (en),
    .div_i       (div),
    .rs232_rxd_i (rxd),
    .rs232_rts_o (rts),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .level_o     (level),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
`ifdef IOB_UART_RX_PARITY_EN
    .parity_err_o(parity_err),
`endif
    .clr_err_i   (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, data (LSB first), optional parity, then sets the stop bit
  // and returns at the start of the stop bit (16 cycles per bit).
  task automatic start_frame(input logic [7:0] d, input logic par, input logic stop);
    rxd = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(16);
    end
`ifdef IOB_UART_RX_PARITY_EN
    rxd = par;
    cyc(16);
`else
    if (par === 1'bz) rxd = 1'b0;
`endif
    rxd = stop;
  endtask

  task automatic send(input logic [7:0] d);
    start_frame(d, ^d, 1'b1);
    cyc(16);
    rxd = 1'b1;
    cyc(2);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, data, exp);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  initial begin
    arst_n  = 1'b0;
    en      = 1'b1;
    div     = 16'd16;
    rxd     = 1'b1;
    ready   = 1'b0;
    clr_err = 1'b0;
    cyc(3);
    chk("reset_rts", rts, 0);
    chk("reset_valid", valid, 0);
    chk("reset_level", level, 0);
    chk("reset_data", data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overflow", overflow, 0);
    arst_n = 1'b1;
    cyc(1);
    chk("rts_after_reset", rts, 1);
    cyc(4);

    // Latency: byte appears one cycle after the stop sample at start+154.
    start_frame(8'hA5, ^8'hA5, 1'b1);
    cyc(10 + FX);
    chk("a5_level_before", level, 0);
    cyc(1);
    chk("a5_level", level, 1);
    chk("a5_valid", valid, 1);
    chk("a5_data", data, 8'hA5);
    chk("a5_frame_err", frame_err, 0);
    chk("a5_overflow", overflow, 0);
    cyc(5);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_level_after_pop", level, 0);

    // Framing error followed by a long low line: no retrigger.
    start_frame(8'h3C, ^8'h3C, 1'b0);
    cyc(16 + 20);
    chk("fe_flag", frame_err, 1);
    chk("fe_level", level, 0);
    clr_pulse();
    cyc(150);
    chk("fe_no_retrigger", frame_err, 0);
    chk("fe_no_push", level, 0);
    rxd = 1'b1;
    cyc(20);
    send(8'h01);
    chk("fe_recover_level", level, 1);
    pop_chk("fe_recover_data", 8'h01);

    // Flow control and overflow with depth 16, margin 4.
    for (int i = 0; i < 11; i++) send(8'h10 + 8'(i));
    chk("rts_at_11", rts, 1);
    send(8'h1B);
    chk("rts_at_12", rts, 0);
    for (int i = 12; i < 16; i++) send(8'h10 + 8'(i));
    chk("full_level", level, 16);
    chk("full_overflow_clear", overflow, 0);
    send(8'hEE);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 16);
    chk("ovf_head", data, 8'h10);
    clr_pulse();
    chk("ovf_cleared", overflow, 0);

    // Full FIFO: push coincident with pop.
    start_frame(8'h77, ^8'h77, 1'b1);
    cyc(10 + FX);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("pp_overflow", overflow, 0);
    chk("pp_level", level, 16);
    cyc(5);
    for (int i = 1; i < 16; i++) pop_chk("drain", 8'h10 + 8'(i));
    pop_chk("drain_tail", 8'h77);
    chk("drain_level", level, 0);
    chk("drain_rts", rts, 1);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("pop_empty_level", level, 0);

    // Short glitch never becomes a frame.
    rxd = 1'b0;
    cyc(6);
    rxd = 1'b1;
    cyc(200);
    chk("glitch_level", level, 0);
    chk("glitch_frame_err", frame_err, 0);

    // Asynchronous reset in the middle of a frame.
    send(8'h5A);
    chk("pre_reset_level", level, 1);
    rxd = 1'b0;
    cyc(50);
    arst_n = 1'b0;
    #1;
    chk("midreset_valid", valid, 0);
    chk("midreset_level", level, 0);
    chk("midreset_data", data, 0);
    chk("midreset_rts", rts, 0);
    rxd = 1'b1;
    cyc(3);
    arst_n = 1'b1;
    cyc(5);
    chk("postreset_rts", rts, 1);
    send(8'hC3);
    chk("postreset_level", level, 1);
    pop_chk("postreset_data", 8'hC3);

`ifdef IOB_UART_RX_PARITY_EN
    start_frame(8'h07, 1'b0, 1'b1);
    cyc(20);
    chk("par_err_flag", parity_err, 1);
    chk("par_err_level", level, 0);
    clr_pulse();
    chk("par_err_cleared", parity_err, 0);
    rxd = 1'b1;
    cyc(4);
    start_frame(8'h07, 1'b1, 1'b1);
    cyc(20);
    chk("par_ok_level", level, 1);
    chk("par_ok_data", data, 8'h07);
    chk("par_ok_flag", parity_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
